// File: rtl/srpt_fetch_queue_credit.sv
// srpt_fetch_queue_credit
//
// Sorted fetch queue that turns pending message fetches into fixed-size
// cache-block read requests, always serving the message with the fewest
// remaining bytes first (shortest remaining processing time). Issued fetches
// consume a credit; completions returned on DONE_VALID give credits back.
//
// Ports:
//   ap_clk         clock, all logic on the rising edge
//   ap_rst         synchronous reset, active-low
//   S_AXIS_*       enqueue stream, TDATA = {msg_len, dbuff_id, rpc_id}
//   M_AXIS_*       fetch request stream,
//                  TDATA = {last, chunk_len, offset, dbuff_id, rpc_id}
//   DONE_VALID     one-cycle pulse per completed fetch (returns one credit)
//   occupancy      number of valid queue slots
//
// Handshake: a transfer happens on a rising edge where VALID and READY are
// both high. M_AXIS_TDATA/TVALID hold while TVALID && !TREADY unless a
// shorter message is enqueued and takes over the head.
module srpt_fetch_queue_credit #(
  parameter int MAX_RPCS     = 64,
  parameter int ID_W         = 16,
  parameter int DBUFF_W      = 10,
  parameter int LEN_W        = 20,
  parameter int CHUNK_BYTES  = 64,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                              ap_clk,
  input  logic                              ap_rst,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  input  logic [ID_W+DBUFF_W+LEN_W-1:0]     S_AXIS_TDATA,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  output logic [ID_W+DBUFF_W+2*LEN_W:0]     M_AXIS_TDATA,
  input  logic                              DONE_VALID,
  output logic [$clog2(MAX_RPCS+1)-1:0]     occupancy
);

  localparam int OCC_W = $clog2(MAX_RPCS+1);
  localparam int CRD_W = $clog2(MAX_INFLIGHT+1);
  localparam logic [LEN_W-1:0] CHUNK     = LEN_W'(CHUNK_BYTES);
  localparam logic [OCC_W-1:0] OCC_MAX   = OCC_W'(MAX_RPCS);
  localparam logic [CRD_W-1:0] CREDIT_MAX = CRD_W'(MAX_INFLIGHT);

  // Slot storage; valid slots are contiguous from slot 0 in ascending
  // order of remaining bytes.
  logic               valid_q [MAX_RPCS];
  logic [ID_W-1:0]    id_q    [MAX_RPCS];
  logic [DBUFF_W-1:0] db_q    [MAX_RPCS];
  logic [LEN_W-1:0]   len_q   [MAX_RPCS];
  logic [LEN_W-1:0]   rem_q   [MAX_RPCS];

  logic               valid_d [MAX_RPCS];
  logic [ID_W-1:0]    id_d    [MAX_RPCS];
  logic [DBUFF_W-1:0] db_d    [MAX_RPCS];
  logic [LEN_W-1:0]   len_d   [MAX_RPCS];
  logic [LEN_W-1:0]   rem_d   [MAX_RPCS];

  // Queue contents after this cycle's issue but before this cycle's insert.
  logic               p_valid [MAX_RPCS];
  logic [ID_W-1:0]    p_id    [MAX_RPCS];
  logic [DBUFF_W-1:0] p_db    [MAX_RPCS];
  logic [LEN_W-1:0]   p_len   [MAX_RPCS];
  logic [LEN_W-1:0]   p_rem   [MAX_RPCS];

  logic [MAX_RPCS-1:0] behind;

  logic [OCC_W-1:0] count_q, count_d;
  logic [CRD_W-1:0] credit_q, credit_d;

  logic [ID_W-1:0]    enq_id;
  logic [DBUFF_W-1:0] enq_db;
  logic [LEN_W-1:0]   enq_len;
  logic               enq_fire;
  logic               enq_ins;

  logic               head_last;
  logic [LEN_W-1:0]   head_chunk;
  logic [LEN_W-1:0]   head_off;
  logic               issue;
  logic               pop;

  assign enq_id  = S_AXIS_TDATA[ID_W-1:0];
  assign enq_db  = S_AXIS_TDATA[ID_W +: DBUFF_W];
  assign enq_len = S_AXIS_TDATA[ID_W+DBUFF_W +: LEN_W];

  assign S_AXIS_TREADY = ap_rst && (count_q < OCC_MAX);
  assign enq_fire      = S_AXIS_TVALID && S_AXIS_TREADY;
  // Zero-length messages complete the handshake but never occupy a slot.
  assign enq_ins       = enq_fire && (enq_len != '0);

  assign head_last  = (rem_q[0] <= CHUNK);
  assign head_chunk = head_last ? rem_q[0] : CHUNK;
  assign head_off   = len_q[0] - rem_q[0];

  assign M_AXIS_TVALID = ap_rst && valid_q[0] && (credit_q != '0);
  assign M_AXIS_TDATA  = {head_last, head_chunk, head_off, db_q[0], id_q[0]};
  assign issue         = M_AXIS_TVALID && M_AXIS_TREADY;
  assign pop           = issue && head_last;

  assign occupancy = count_q;

  // Apply the issue: either drop the head and shift everything down, or
  // shrink the head in place. A shrunk head is still the minimum.
  always_comb begin
    for (int i = 0; i < MAX_RPCS; i++) begin
      p_valid[i] = valid_q[i];
      p_id[i]    = id_q[i];
      p_db[i]    = db_q[i];
      p_len[i]   = len_q[i];
      p_rem[i]   = rem_q[i];
    end
    if (pop) begin
      for (int i = 0; i < MAX_RPCS-1; i++) begin
        p_valid[i] = valid_q[i+1];
        p_id[i]    = id_q[i+1];
        p_db[i]    = db_q[i+1];
        p_len[i]   = len_q[i+1];
        p_rem[i]   = rem_q[i+1];
      end
      p_valid[MAX_RPCS-1] = 1'b0;
    end else if (issue) begin
      p_rem[0] = rem_q[0] - CHUNK;
    end
  end

  // behind[i]: the new entry belongs after post-issue slot i. Using <=
  // places it after existing equal entries. The vector is a prefix of ones.
  always_comb begin
    for (int i = 0; i < MAX_RPCS; i++) begin
      behind[i] = p_valid[i] && (p_rem[i] <= enq_len);
    end
  end

  // Compare-and-shift insert: each slot keeps its post-issue entry, takes
  // the new entry at the insertion point, or takes its lower neighbour.
  always_comb begin
    if (!enq_ins || behind[0]) begin
      valid_d[0] = p_valid[0];
      id_d[0]    = p_id[0];
      db_d[0]    = p_db[0];
      len_d[0]   = p_len[0];
      rem_d[0]   = p_rem[0];
    end else begin
      valid_d[0] = 1'b1;
      id_d[0]    = enq_id;
      db_d[0]    = enq_db;
      len_d[0]   = enq_len;
      rem_d[0]   = enq_len;
    end
    for (int i = 1; i < MAX_RPCS; i++) begin
      if (!enq_ins || behind[i]) begin
        valid_d[i] = p_valid[i];
        id_d[i]    = p_id[i];
        db_d[i]    = p_db[i];
        len_d[i]   = p_len[i];
        rem_d[i]   = p_rem[i];
      end else if (behind[i-1]) begin
        valid_d[i] = 1'b1;
        id_d[i]    = enq_id;
        db_d[i]    = enq_db;
        len_d[i]   = enq_len;
        rem_d[i]   = enq_len;
      end else begin
        valid_d[i] = p_valid[i-1];
        id_d[i]    = p_id[i-1];
        db_d[i]    = p_db[i-1];
        len_d[i]   = p_len[i-1];
        rem_d[i]   = p_rem[i-1];
      end
    end
  end

  always_comb begin
    count_d = count_q;
    case ({enq_ins, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Issue and completion in the same cycle cancel; returns beyond the
  // limit are ignored.
  always_comb begin
    credit_d = credit_q;
    if (issue && !DONE_VALID) begin
      credit_d = credit_q - 1'b1;
    end else if (!issue && DONE_VALID && (credit_q != CREDIT_MAX)) begin
      credit_d = credit_q + 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst) begin
      for (int i = 0; i < MAX_RPCS; i++) begin
        valid_q[i] <= 1'b0;
        id_q[i]    <= '0;
        db_q[i]    <= '0;
        len_q[i]   <= '0;
        rem_q[i]   <= '0;
      end
      count_q  <= '0;
      credit_q <= CREDIT_MAX;
    end else begin
      for (int i = 0; i < MAX_RPCS; i++) begin
        valid_q[i] <= valid_d[i];
        id_q[i]    <= id_d[i];
        db_q[i]    <= db_d[i];
        len_q[i]   <= len_d[i];
        rem_q[i]   <= rem_d[i];
      end
      count_q  <= count_d;
      credit_q <= credit_d;
    end
  end

endmodule

// File: tb/tb_srpt_fetch_queue_credit.sv
// Testbench for srpt_fetch_queue_credit.
// Expected fetch requests are pushed to exp_q when messages are enqueued, in
// the order the shortest-remaining-first policy must serve them, and popped
// and compared each time the DUT issues a request.
module tb_srpt_fetch_queue_credit;

  localparam int MAX_RPCS     = 64;
  localparam int ID_W         = 16;
  localparam int DBUFF_W      = 10;
  localparam int LEN_W        = 20;
  localparam int CHUNK_BYTES  = 64;
  localparam int MAX_INFLIGHT = 8;
  localparam int ENQ_W = ID_W + DBUFF_W + LEN_W;
  localparam int REQ_W = ID_W + DBUFF_W + 2*LEN_W + 1;
  localparam int OCC_W = $clog2(MAX_RPCS+1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [ENQ_W-1:0] s_data = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [REQ_W-1:0] m_data;
  logic             done_auto = 1'b0;
  logic             done_pulse = 1'b0;
  logic             done_i;
  logic [OCC_W-1:0] occ;

  assign done_i = done_auto | done_pulse;

  srpt_fetch_queue_credit #(
    .MAX_RPCS(MAX_RPCS), .ID_W(ID_W), .DBUFF_W(DBUFF_W), .LEN_W(LEN_W),
    .CHUNK_BYTES(CHUNK_BYTES), .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .ap_clk(clk),
    .ap_rst(rst_n),
    .S_AXIS_TVALID(s_valid),
    .S_AXIS_TREADY(s_ready),
    .S_AXIS_TDATA(s_data),
    .M_AXIS_TVALID(m_valid),
    .M_AXIS_TREADY(m_ready),
    .M_AXIS_TDATA(m_data),
    .DONE_VALID(done_i),
    .occupancy(occ)
  );

  // ---------------- scoreboard ----------------
  logic [REQ_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_miss = 0;
  int issue_cnt = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REQ_W-1:0] mk_req(input int rpc, input int db, input int off,
                                              input int cl, input bit last);
    logic [REQ_W-1:0] r;
    r = {last, LEN_W'(cl), LEN_W'(off), DBUFF_W'(db), ID_W'(rpc)};
    return r;
  endfunction

  // Push chunks [lo, hi) of a message, cutting it front to back.
  task automatic push_chunks(input int rpc, input int db, input int len, input int lo, input int hi);
    int rem, off, idx, cl;
    rem = len; off = 0; idx = 0;
    while (rem > 0) begin
      cl = (rem > CHUNK_BYTES) ? CHUNK_BYTES : rem;
      if (idx >= lo && idx < hi) exp_q.push_back(mk_req(rpc, db, off, cl, rem <= CHUNK_BYTES));
      rem = rem - cl;
      off = off + cl;
      idx++;
    end
  endtask

  // Monitor: the handshake seen here completes on the following rising edge.
  always @(negedge clk) begin
    logic [REQ_W-1:0] e;
    if (m_valid && m_ready) begin
      issue_cnt++;
      // An all-ones request can never be legal (chunk_len <= 64), so an
      // unexpected issue always miscompares.
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      check("fetch", m_data, e);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic enqueue(input int rpc, input int db, input int len);
    bit ok;
    int t;
    s_data = {LEN_W'(len), DBUFF_W'(db), ID_W'(rpc)};
    s_valid = 1'b1;
    ok = 1'b0;
    t = 0;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk); #1;
      t++;
    end
    s_valid = 1'b0;
    check("enq_accept", ok, 1);
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk); #1;
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", m_valid, 0);
    check("rst_tready", s_ready, 0);
    check("rst_occ", occ, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_tready", s_ready, 1);
    check("post_rst_tvalid", m_valid, 0);
    cycles(1);

    // Single entry of 10000 bytes
    m_ready = 1'b1;
    done_auto = 1'b1;
    base = issue_cnt;
    push_chunks(1, 0, 10000, 0, 1000);
    enqueue(1, 0, 10000);
    wait_drain(400);
    @(negedge clk);
    check("single_count", issue_cnt - base, 157);
    check("single_tvalid", m_valid, 0);
    check("single_occ", occ, 0);
    cycles(1);

    // SRPT ordering with FIFO tie-break
    m_ready = 1'b0;
    enqueue(1, 1, 1000);
    enqueue(2, 2, 100);
    enqueue(3, 3, 100);
    @(negedge clk);
    check("srpt_occ", occ, 3);
    check("srpt_head", m_data, mk_req(2, 2, 0, 64, 1'b0));
    push_chunks(2, 2, 100, 0, 100);
    push_chunks(3, 3, 100, 0, 100);
    push_chunks(1, 1, 1000, 0, 100);
    cycles(1);
    m_ready = 1'b1;
    wait_drain(200);
    m_ready = 1'b0;

    // Credit limit
    done_auto = 1'b0;
    m_ready = 1'b1;
    base = issue_cnt;
    push_chunks(7, 2, 4096, 0, 8);
    enqueue(7, 2, 4096);
    cycles(20);
    @(negedge clk);
    check("credit_8", issue_cnt - base, 8);
    check("credit_tvalid", m_valid, 0);
    push_chunks(7, 2, 4096, 8, 9);
    cycles(1);
    done_pulse = 1'b1;
    cycles(1);
    done_pulse = 1'b0;
    cycles(6);
    @(negedge clk);
    check("credit_9", issue_cnt - base, 9);
    check("credit_tvalid2", m_valid, 0);
    push_chunks(7, 2, 4096, 9, 64);
    cycles(1);
    done_auto = 1'b1;
    wait_drain(200);
    m_ready = 1'b0;

    // Full queue and boundaries
    for (int i = 0; i < MAX_RPCS; i++) enqueue(100 + i, i, 128);
    @(negedge clk);
    check("full_tready", s_ready, 0);
    check("full_occ", occ, 64);
    push_chunks(100, 0, 128, 0, 10);
    cycles(1);
    m_ready = 1'b1;
    cycles(2);
    m_ready = 1'b0;
    @(negedge clk);
    check("after_pop_occ", occ, 63);
    check("after_pop_tready", s_ready, 1);
    cycles(1);
    enqueue(999, 5, 0);
    @(negedge clk);
    check("zero_len_occ", occ, 63);
    for (int i = 1; i < MAX_RPCS; i++) push_chunks(100 + i, i, 128, 0, 10);
    cycles(1);
    m_ready = 1'b1;
    wait_drain(400);
    m_ready = 1'b0;
    @(negedge clk);
    check("full_drain_occ", occ, 0);
    cycles(1);

    // Simultaneous issue of a last chunk and enqueue
    push_chunks(1, 3, 64, 0, 10);
    push_chunks(5, 4, 32, 0, 10);
    enqueue(1, 3, 64);
    m_ready = 1'b1;
    s_data = {LEN_W'(32), DBUFF_W'(4), ID_W'(5)};
    s_valid = 1'b1;
    @(negedge clk);
    check("simul_tready", s_ready, 1);
    cycles(1);
    s_valid = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    check("simul_occ", occ, 1);
    check("simul_head", m_data, mk_req(5, 4, 0, 32, 1'b1));
    check("simul_pending", exp_q.size(), 1);
    cycles(1);
    m_ready = 1'b1;
    wait_drain(20);
    m_ready = 1'b0;

    // Reset mid-stream with entries queued and fetches in flight
    done_auto = 1'b0;
    push_chunks(10, 0, 1000, 0, 4);
    enqueue(10, 0, 1000);
    enqueue(11, 0, 1000);
    enqueue(12, 0, 1000);
    m_ready = 1'b1;
    cycles(4);
    m_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_occ", occ, 3);
    check("pre_rst_sb", exp_q.size(), 0);
    cycles(1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_tvalid", m_valid, 0);
    check("mid_rst_tready", s_ready, 0);
    cycles(1);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_occ", occ, 0);
    check("mid_rst_tvalid2", m_valid, 0);
    cycles(1);
    base = issue_cnt;
    push_chunks(20, 1, 4096, 0, 8);
    enqueue(20, 1, 4096);
    m_ready = 1'b1;
    cycles(20);
    @(negedge clk);
    check("rst_credit_8", issue_cnt - base, 8);
    check("rst_credit_tvalid", m_valid, 0);
    check("rst_credit_sb", exp_q.size(), 0);
    m_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    check("timeout", 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/srpt_fetch_queue_credit.md
Name: srpt_fetch_queue_credit

Overview:
- Parametrised successor to the single-mode SRPT fetch queue.
- Holds up to MAX_RPCS pending message fetches, sorted by remaining bytes, and issues fixed-size cache-block fetch requests for the shortest-remaining message first (SRPT).
- Adds per-request byte offsets, a last-chunk flag, an outstanding-fetch credit limit with a completion return port, and an occupancy output.
- Sits between the sendmsg/RPC-state path (enqueue) and the DMA read engine (fetch requests).

Parameters:
- MAX_RPCS, 64, number of sorted queue slots.
- ID_W, 16, RPC ID width.
- DBUFF_W, 10, data buffer ID width.
- LEN_W, 20, message length / remaining-bytes width.
- CHUNK_BYTES, 64, fetch granularity in bytes; power of two.
- MAX_INFLIGHT, 8, maximum issued-but-uncompleted fetches; >=1.

Ports:
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst  in  1  synchronous reset, active-low.
- S_AXIS_TVALID  in  1  enqueue valid.
- S_AXIS_TREADY  out  1  enqueue ready.
- S_AXIS_TDATA  in  ID_W+DBUFF_W+LEN_W  {msg_len, dbuff_id, rpc_id}, rpc_id in the LSBs.
- M_AXIS_TVALID  out  1  fetch request valid.
- M_AXIS_TREADY  in  1  fetch request ready.
- M_AXIS_TDATA  out  ID_W+DBUFF_W+2*LEN_W+1  {last, chunk_len, offset, dbuff_id, rpc_id}; chunk_len uses the LEN_W field.
- DONE_VALID  in  1  one-cycle pulse; one fetch completed, returns one credit.
- occupancy  out  clog2(MAX_RPCS+1)  number of valid slots.

Behaviour:
- Reset (ap_rst==0 at a clock edge):
  - All slots invalid; occupancy=0.
  - Credits = MAX_INFLIGHT.
  - M_AXIS_TVALID=0; S_AXIS_TREADY=0 while ap_rst==0.
  - Reset mid-operation discards all entries and outstanding credits immediately.
- Slot contents: valid, rpc_id, dbuff_id, msg_len, remaining.
- Sort order: slots ordered ascending by remaining; slot 0 is the head.
  - Ties: a new entry goes behind existing equal entries (FIFO among equals).
- S_AXIS_TREADY = ap_rst && (occupancy < MAX_RPCS).
- Enqueue on S_AXIS_TVALID && S_AXIS_TREADY:
  - Entry is inserted with remaining = msg_len.
  - Parallel compare-and-shift insert; entry is visible in a slot on the next cycle.
  - Head change is visible on M_AXIS_TDATA one cycle after acceptance.
  - msg_len==0: handshake completes, entry is dropped, occupancy unchanged.
- Fetch request output:
  - M_AXIS_TVALID = slot0.valid && credits>0.
  - M_AXIS_TDATA is combinational from slot 0, no added latency:
    - chunk_len = min(remaining, CHUNK_BYTES).
    - offset = msg_len - remaining.
    - last = (remaining <= CHUNK_BYTES).
- Issue on M_AXIS_TVALID && M_AXIS_TREADY:
  - Credits decrement.
  - If last, slot 0 is removed and all slots shift down one; otherwise slot0.remaining -= CHUNK_BYTES.
  - Head stays at slot 0 after the decrement: it was the minimum and only got smaller, so no re-sort is needed.
- Simultaneous enqueue and issue in one cycle:
  - Both are accepted.
  - Insert compares against the post-issue head (updated remaining, or slot 1 if the head was removed).
  - Each slot selects from {hold, slot i+1, slot i-1, new entry}.
  - occupancy changes by the net amount.
- Credits:
  - DONE_VALID increments credits, saturating at MAX_INFLIGHT; over-returns are ignored.
  - Issue and DONE_VALID in the same cycle leave credits unchanged.
  - credits==0: M_AXIS_TVALID low; the head is held.
- AXIS rules: TDATA/TVALID stay stable while TVALID && !TREADY, except when a higher-priority enqueue displaces the head. Preemption of the head is permitted (SRPT); the DMA consumer tolerates it.
- Widths: all arithmetic in LEN_W bits unsigned. msg_len must be < 2^LEN_W; no wrap.

Test Plan:
- Single entry: enqueue {rpc 1, dbuff 0, len 10000}, TREADY=1, DONE_VALID each cycle -> 157 requests; 156 with chunk_len 64 and offsets 0..9920; final request offset 9984, chunk_len 16, last=1; then TVALID=0, occupancy=0.
- SRPT ordering: enqueue len 1000 (rpc 1), then len 100 (rpc 2), then len 100 (rpc 3) -> rpc 2 issues 2 chunks (64, 36 last), then rpc 3 (64, 36 last), then rpc 1 (16 chunks, final 40 last).
- Credit limit: MAX_INFLIGHT=8, no DONE_VALID, enqueue len 4096 -> exactly 8 issues, then TVALID=0; one DONE_VALID pulse -> exactly one more issue.
- Full/boundary: 64 enqueues of len 128 -> TREADY=0, occupancy=64. One full drain of the head (2 issues) -> TREADY=1. Enqueue of len 0 -> accepted, occupancy unchanged.
- Simultaneous: head rpc 1 at remaining 64 (last); in the same cycle issue it and enqueue rpc 5 len 32 -> rpc 1 removed; next head is rpc 5 with chunk_len 32, last=1.
- Reset mid-stream: assert ap_rst=0 for one cycle with 3 entries and 4 in flight -> TVALID=0, occupancy=0, then the full MAX_INFLIGHT issues are available after new enqueues.
